vga_ctrl: RTL

VGA_CTRL -- requirements
Module: vga_ctrl

---
 rtl/vga_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/vga_ctrl.sv
// vga_ctrl: VGA raster timing generator with a one-clock-ahead pixel request port.
//   vga_clk     pixel clock, all logic on the rising edge
//   rst         synchronous active-high reset
//   pix_data    RGB565 pixel from the image generator, valid one clock after pix_x/pix_y
//   pix_x/pix_y requested column/row (10'h3FF outside the request window / active lines)
//   hsync/vsync registered active-low sync pulses
//   de          registered display enable, high while rgb carries a visible pixel
//   rgb         registered RGB565 pixel, 0 while de is low
//   frame_start registered one-clock pulse at the start of each frame
module vga_ctrl #(
    parameter int unsigned H_SYNC  = 96,
    parameter int unsigned H_BACK  = 48,
    parameter int unsigned H_ACT   = 640,
    parameter int unsigned H_FRONT = 16,
    parameter int unsigned V_SYNC  = 2,
    parameter int unsigned V_BACK  = 33,
    parameter int unsigned V_ACT   = 480,
    parameter int unsigned V_FRONT = 10
) (
    input  logic        vga_clk,
    input  logic        rst,
    input  logic [15:0] pix_data,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [15:0] rgb,
    output logic        frame_start
);

    localparam int unsigned CW      = 10;
    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_ACT + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_ACT + V_FRONT;
    localparam int unsigned HA0     = H_SYNC + H_BACK;
    localparam int unsigned VA0     = V_SYNC + V_BACK;

    localparam logic [CW-1:0] H_LAST_W = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST_W = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_SYNC_W = CW'(H_SYNC);
    localparam logic [CW-1:0] V_SYNC_W = CW'(V_SYNC);
    localparam logic [CW-1:0] HA0_W    = CW'(HA0);
    localparam logic [CW-1:0] HA1_W    = CW'(HA0 + H_ACT);
    localparam logic [CW-1:0] REQ0_W   = CW'(HA0 - 1);
    localparam logic [CW-1:0] REQ1_W   = CW'(HA0 + H_ACT - 1);
    localparam logic [CW-1:0] VA0_W    = CW'(VA0);
    localparam logic [CW-1:0] VA1_W    = CW'(VA0 + V_ACT);
    localparam logic [CW-1:0] NONE_W   = 10'h3FF;

    logic [CW-1:0] cnt_h;
    logic [CW-1:0] cnt_v;
    logic          h_last;
    logic          v_last;
    logic          line_act;
    logic          pix_act;
    logic          req_win;

    assign h_last = (cnt_h == H_LAST_W);
    assign v_last = (cnt_v == V_LAST_W);

    // Horizontal/vertical position counters; cnt_v advances only on the line wrap.
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            cnt_h <= '0;
            cnt_v <= '0;
        end else begin
            cnt_h <= h_last ? '0 : cnt_h + CW'(1);
            if (h_last) begin
                cnt_v <= v_last ? '0 : cnt_v + CW'(1);
            end
        end
    end

    // Visible window, and the request window one clock earlier so the
    // generator's registered pixel lands on the same edge as de.
    always_comb begin
        line_act = (cnt_v >= VA0_W) && (cnt_v < VA1_W);
        pix_act  = line_act && (cnt_h >= HA0_W) && (cnt_h < HA1_W);
        req_win  = line_act && (cnt_h >= REQ0_W) && (cnt_h < REQ1_W);
    end

    // Request coordinates are forced to "none" while reset is asserted.
    always_comb begin
        pix_x = NONE_W;
        pix_y = NONE_W;
        if (!rst && req_win) begin
            pix_x = cnt_h - REQ0_W;
        end
        if (!rst && line_act) begin
            pix_y = cnt_v - VA0_W;
        end
    end

    // Output stage: one register from the counters for every timing output.
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            de          <= 1'b0;
            rgb         <= '0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= !(cnt_h < H_SYNC_W);
            vsync       <= !(cnt_v < V_SYNC_W);
            de          <= pix_act;
            rgb         <= pix_act ? pix_data : 16'h0000;
            frame_start <= (cnt_h == '0) && (cnt_v == '0);
        end
    end

endmodule
